// File: rtl/wm8731_i2s_tx.sv
// I2S master transmitter for the WM8731 DAC path: one-pair holding buffer,
// BCLK/DACLRCK generation and MSB-first serialisation into 32-bit slots.
module wm8731_i2s_tx #(
    parameter int BCLK_HALF = 4,
    parameter int SAMPLE_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                frame_start,
    output logic                underrun
);

    localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam int PAD_W = 32 - SAMPLE_W;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [63:0]         frame_sr;

    logic       fall_evt;
    logic       latch;
    logic       accept;
    logic [5:0] bit_nxt;
    logic [5:0] sr_idx;

    // reset gates s_ready so every output reads 0 while reset is asserted
    assign s_ready = reset & enable & ~hold_full;

    always_comb begin
        fall_evt = enable && (div_cnt == DIV_LAST) && aud_bclk;
        bit_nxt  = bit_cnt + 6'd1;
        latch    = fall_evt && (bit_nxt == 6'd0);
        // 64-k folded into 6 bits; only used for k in 1..63
        sr_idx   = 6'd0 - bit_nxt;
        accept   = s_valid && s_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            bit_cnt     <= 6'd63;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            frame_sr    <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!enable) begin
            div_cnt     <= '0;
            bit_cnt     <= 6'd63;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            frame_sr    <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= latch;
            underrun    <= latch && !hold_full;

            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                aud_bclk <= ~aud_bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                if (latch) begin
                    aud_daclrck <= 1'b0;
                    aud_dacdat  <= 1'b0;
                    frame_sr    <= hold_full ? {hold_l, {PAD_W{1'b0}}, hold_r, {PAD_W{1'b0}}}
                                             : 64'h0;
                end else begin
                    aud_daclrck <= bit_nxt[5];
                    aud_dacdat  <= frame_sr[sr_idx];
                end
            end

            // consume needs a full buffer and accept an empty one, so they never collide
            if (latch && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= s_left;
                hold_r    <= s_right;
            end
        end
    end

endmodule
